// File: rtl/panel_pkg.sv
// panel_pkg: shared widths, blank column pattern and FSM state type for the scrolling panel
package panel_pkg;
    localparam int CHAR_W = 9;
    localparam int ROW_W = 7;
    localparam int COLS_PER_CHAR = 6;
    localparam logic [ROW_W-1:0] BLANK_COL = 7'h7F;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/panel_scroller_if.sv
// panel_scroller_if: message character stream into the scroller
//   msg_valid - character present on msg_char
//   msg_ready - receiver accepts a character this cycle
//   msg_char  - character code
//   msg_last  - final character of the message, qualified by msg_valid
interface panel_scroller_if;
    import panel_pkg::*;
    logic              msg_valid;
    logic              msg_ready;
    logic              msg_last;
    logic [CHAR_W-1:0] msg_char;
    modport master (output msg_valid, msg_char, msg_last, input msg_ready);
    modport slave  (input msg_valid, msg_char, msg_last, output msg_ready);
endinterface

// File: rtl/panel_scan_timer.sv
// panel_scan_timer: column-scan and scroll-step prescaler
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_clr         - synchronous clear of both prescalers; also suppresses ticks
//   o_scan_tick   - high in the last cycle of each SCAN_DIV-cycle column slot
//   o_scroll_tick - high on the scan tick that completes FRAME_TICKS slots
module panel_scan_timer #(
    parameter int SCAN_DIV    = 1000,
    parameter int FRAME_TICKS = 400
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_scan_tick,
    output logic o_scroll_tick
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int FW = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
    logic [DW-1:0] r_div;
    logic [FW-1:0] r_frm;
    assign o_scan_tick   = !i_clr && r_div == DW'(SCAN_DIV - 1);
    assign o_scroll_tick = o_scan_tick && r_frm == FW'(FRAME_TICKS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_frm <= '0;
        end else if (i_clr) begin
            r_div <= '0;
            r_frm <= '0;
        end else begin
            r_div <= o_scan_tick ? '0 : r_div + DW'(1);
            if (o_scan_tick)
                r_frm <= o_scroll_tick ? '0 : r_frm + FW'(1);
        end
    end
endmodule

// File: rtl/panel_scroller.sv
// panel_scroller: stores a message, feeds codes to the decoder, scrolls columns into a frame buffer and scans it onto the panel
//   clk, rst_n        - clock, asynchronous active-low reset
//   bus               - message stream (slave side)
//   o_char_code       - code presented to the decoder (registered)
//   i_dec_col_0..5    - decoder column patterns for o_char_code, active low
//   o_row_n           - active-low row drive for the selected column
//   o_col_sel         - one-hot active-high column select
module panel_scroller
    import panel_pkg::*;
#(
    parameter int NUM_COLS   = 8,
    parameter int MAX_LEN    = 16,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    panel_scroller_if.slave     bus,
    output logic [CHAR_W-1:0]   o_char_code,
    input  logic [ROW_W-1:0]    i_dec_col_0,
    input  logic [ROW_W-1:0]    i_dec_col_1,
    input  logic [ROW_W-1:0]    i_dec_col_2,
    input  logic [ROW_W-1:0]    i_dec_col_3,
    input  logic [ROW_W-1:0]    i_dec_col_4,
    input  logic [ROW_W-1:0]    i_dec_col_5,
    output logic [ROW_W-1:0]    o_row_n,
    output logic [NUM_COLS-1:0] o_col_sel
);
    localparam int CW = $clog2(NUM_COLS);
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int KW = $clog2(COLS_PER_CHAR);
    state_t              r_state, w_state_nx;
    logic [LW-1:0]       r_len;
    logic [IW-1:0]       r_char_idx;
    logic [KW-1:0]       r_col_idx;
    logic [CW-1:0]       r_col_ptr, w_col_ptr_nx;
    logic [ROW_W-1:0]    r_fb [NUM_COLS];
    logic [ROW_W-1:0]    w_fb_nx [NUM_COLS];
    logic [CHAR_W-1:0]   r_mem [MAX_LEN];
    logic [ROW_W-1:0]    w_dec [COLS_PER_CHAR];
    logic [CHAR_W-1:0]   r_char_code;
    logic [ROW_W-1:0]    r_row_n;
    logic [NUM_COLS-1:0] r_col_sel;
    logic                w_xfer, w_first, w_run_entry, w_clr, w_we;
    logic                w_scan_tick, w_step, w_col_wrap;
    logic [IW-1:0]       w_wr_idx;
    assign w_dec          = '{i_dec_col_0, i_dec_col_1, i_dec_col_2, i_dec_col_3, i_dec_col_4, i_dec_col_5};
    assign bus.msg_ready  = 1'b1;
    assign w_xfer         = bus.msg_valid && bus.msg_ready;
    // Any transfer outside LOAD starts a fresh message
    assign w_first        = w_xfer && r_state != LOAD;
    assign w_run_entry    = w_xfer && bus.msg_last;
    // Prescalers idle outside RUN and restart on every RUN entry; a clear also masks
    // the ticks, so a transfer always wins over a coincident scroll step
    assign w_clr          = w_state_nx != RUN || w_run_entry;
    assign w_col_wrap     = r_col_idx == KW'(COLS_PER_CHAR - 1);
    assign w_we           = w_first || (w_xfer && r_len != LW'(MAX_LEN));
    assign w_wr_idx       = w_first ? '0 : IW'(r_len);
    assign w_col_ptr_nx   = w_clr ? '0 : !w_scan_tick ? r_col_ptr :
                            r_col_ptr == CW'(NUM_COLS - 1) ? '0 : r_col_ptr + CW'(1);
    assign o_char_code    = r_char_code;
    assign o_row_n        = r_row_n;
    assign o_col_sel      = r_col_sel;
    panel_scan_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .FRAME_TICKS (NUM_COLS * SCROLL_DIV)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clr         (w_clr),
        .o_scan_tick   (w_scan_tick),
        .o_scroll_tick (w_step)
    );
    always_comb begin
        w_state_nx = r_state;
        if (w_xfer)
            w_state_nx = bus.msg_last ? RUN : LOAD;
    end
    always_comb begin
        for (int i = 0; i < NUM_COLS; i++)
            w_fb_nx[i] = w_first ? BLANK_COL : r_fb[i];
        if (w_step) begin
            for (int i = 0; i < NUM_COLS - 1; i++)
                w_fb_nx[i] = r_fb[i + 1];
            w_fb_nx[NUM_COLS-1] = w_dec[r_col_idx];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_char_idx  <= '0;
            r_col_idx   <= '0;
            r_col_ptr   <= '0;
            r_char_code <= '0;
            r_row_n     <= BLANK_COL;
            r_col_sel   <= '0;
            for (int i = 0; i < NUM_COLS; i++)
                r_fb[i] <= BLANK_COL;
        end else begin
            r_state     <= w_state_nx;
            r_col_ptr   <= w_col_ptr_nx;
            r_char_code <= r_state == IDLE ? '0 : r_mem[r_char_idx];
            // Panel outputs are built from next-state values so select and rows
            // always describe the same column and follow state changes on the same edge
            r_row_n     <= w_state_nx == RUN ? w_fb_nx[w_col_ptr_nx] : BLANK_COL;
            r_col_sel   <= w_state_nx == RUN ? NUM_COLS'(1) << w_col_ptr_nx : '0;
            for (int i = 0; i < NUM_COLS; i++)
                r_fb[i] <= w_fb_nx[i];
            if (w_first)
                r_len <= LW'(1);
            else if (w_we)
                r_len <= r_len + LW'(1);
            if (w_first || w_run_entry) begin
                r_char_idx <= '0;
                r_col_idx  <= '0;
            end else if (w_step) begin
                r_col_idx <= w_col_wrap ? '0 : r_col_idx + KW'(1);
                if (w_col_wrap)
                    r_char_idx <= LW'(r_char_idx) == r_len - LW'(1) ? '0 : r_char_idx + IW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_wr_idx] <= bus.msg_char;
    end
endmodule

// File: tb/tb_panel_scroller.sv
// tb_panel_scroller: directed checks of load, scan, scroll, wrap, overflow, preempt and async reset
module tb_panel_scroller;
    import panel_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] char_code;
    logic [6:0] row_n;
    logic [3:0] col_sel;
    logic [6:0] d0, d1, d2, d3, d4, d5;
    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] msg [4];
    int         mlen = 1;
    logic       watch = 1'b0;
    logic [8:0] bad0 = 9'h0AA;
    logic [8:0] bad1 = 9'h155;
    int         bad_hits = 0;
    panel_scroller_if bus();
    always #5 clk = ~clk;
    function automatic logic [6:0] dec(input logic [8:0] c, input int k);
        return (c[6:0] + 7'(k * 17)) ^ 7'h40;
    endfunction
    assign d0 = dec(char_code, 0);
    assign d1 = dec(char_code, 1);
    assign d2 = dec(char_code, 2);
    assign d3 = dec(char_code, 3);
    assign d4 = dec(char_code, 4);
    assign d5 = dec(char_code, 5);
    panel_scroller #(
        .NUM_COLS   (4),
        .MAX_LEN    (4),
        .SCAN_DIV   (2),
        .SCROLL_DIV (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_char_code (char_code),
        .i_dec_col_0 (d0),
        .i_dec_col_1 (d1),
        .i_dec_col_2 (d2),
        .i_dec_col_3 (d3),
        .i_dec_col_4 (d4),
        .i_dec_col_5 (d5),
        .o_row_n     (row_n),
        .o_col_sel   (col_sel)
    );
    always @(negedge clk)
        if (watch && (char_code == bad0 || char_code == bad1))
            bad_hits++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [8:0] c, input logic last);
        bus.msg_char  = c;
        bus.msg_last  = last;
        bus.msg_valid = 1'b1;
        cyc();
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask
    // Column k of the frame after s scroll steps: step t carried column (t-1)%6 of
    // message character ((t-1)/6)%len, and column 3 holds the newest step
    function automatic logic [6:0] exp_fb(input int s, input int k);
        int t = s - (3 - k);
        if (t < 1)
            return 7'h7F;
        return dec(msg[((t - 1) / 6) % mlen], (t - 1) % 6);
    endfunction
    // One 8-cycle scroll period starting just after the edge that completed step s
    task automatic check_frame(input int s, input bit stop_early);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("col_sel s%0d c%0d", s, c), 32'(col_sel), 32'(1) << (c / 2));
            check($sformatf("row_n s%0d c%0d", s, c), 32'(row_n), 32'(exp_fb(s, c / 2)));
            if (c == 7)
                check($sformatf("char_code s%0d", s), 32'(char_code), 32'(msg[(s / 6) % mlen]));
            if (!(stop_early && c == 7))
                cyc();
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        bus.msg_char  = '0;
        #11;
        check("reset row_n", 32'(row_n), 32'h7F);
        check("reset col_sel", 32'(col_sel), 32'h0);
        check("reset msg_ready", 32'(bus.msg_ready), 32'h1);
        check("reset char_code", 32'(char_code), 32'h0);
        rst_n = 1'b1;
        cyc();
        check("idle col_sel", 32'(col_sel), 32'h0);
        // Single character repeats every 6 steps
        msg[0] = 9'h041;
        mlen   = 1;
        send(9'h041, 1'b1);
        for (int s = 0; s < 8; s++)
            check_frame(s, 1'b0);
        // Two-character wrap, preempting the running message
        send(9'h048, 1'b0);
        check("load col_sel", 32'(col_sel), 32'h0);
        check("load row_n", 32'(row_n), 32'h7F);
        check("load msg_ready", 32'(bus.msg_ready), 32'h1);
        msg[0] = 9'h048;
        msg[1] = 9'h049;
        mlen   = 2;
        send(9'h049, 1'b1);
        for (int s = 0; s < 13; s++)
            check_frame(s, 1'b0);
        // Overflow: six characters, only the first four are kept
        msg[0] = 9'h1A5;
        msg[1] = 9'h032;
        msg[2] = 9'h0F7;
        msg[3] = 9'h144;
        mlen   = 4;
        for (int i = 0; i < 4; i++)
            send(msg[i], 1'b0);
        send(bad0, 1'b0);
        send(bad1, 1'b1);
        watch = 1'b1;
        for (int s = 0; s < 25; s++)
            check_frame(s, 1'b0);
        // Preempt on the cycle of a scroll tick
        check_frame(25, 1'b1);
        watch = 1'b0;
        check("overflow chars seen", 32'(bad_hits), 32'h0);
        msg[0] = 9'h04B;
        mlen   = 1;
        send(9'h04B, 1'b1);
        for (int s = 0; s < 8; s++)
            check_frame(s, 1'b0);
        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async row_n", 32'(row_n), 32'h7F);
        check("async col_sel", 32'(col_sel), 32'h0);
        check("async msg_ready", 32'(bus.msg_ready), 32'h1);
        check("async char_code", 32'(char_code), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("post reset col_sel", 32'(col_sel), 32'h0);
        check("post reset row_n", 32'(row_n), 32'h7F);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
